ecl_ttl_xlat_arbiter: RTL and testbench

//  Round-robin arbiter and strobe sequencer that shares one 6-bit registered ECL->TTL

---
 rtl/xlat_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/ecl_ttl_xlat_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ecl_ttl_xlat_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/xlat_pkg.sv
// rtl/xlat_pkg.sv - shared state encoding and constants for the ECL->TTL translator arbiter
package xlat_pkg;

  localparam int XLAT_W   = 6;
  localparam int CLRP_CYC = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4,
    CLRP   = 3'd5
  } xlat_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  REQ,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic             any_req
);

  logic found;
  int   idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && REQ[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_req = |REQ;

endmodule

// File: rtl/ecl_ttl_xlat_arbiter.sv
// rtl/ecl_ttl_xlat_arbiter.sv - shares one registered ECL->TTL latch among NREQ requesters
// Optional XQ readback compare is built when XLAT_READBACK_EN is defined.
module ecl_ttl_xlat_arbiter
  import xlat_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic                   CLK,
  input  logic                   MR,
  input  logic [NREQ-1:0]        REQ,
  input  logic [XLAT_W*NREQ-1:0] DATA,
  input  logic                   CLR,
  output logic [NREQ-1:0]        ACK,
  output logic [NREQ-1:0]        GNT,
  output logic                   BUSY,
  output logic [XLAT_W-1:0]      XD,
  output logic                   XCLK,
  output logic                   XMR
`ifdef XLAT_READBACK_EN
  ,
  input  logic [XLAT_W-1:0]      XQ,
  output logic                   RB_ERR,
  output logic [7:0]             RB_CNT
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  xlat_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              clr_pend;

  logic [NREQ-1:0]   pick;
  logic              any_req;
  logic [PTR_W-1:0]  pick_idx;
  logic [XLAT_W-1:0] pick_data;
  logic [PTR_W-1:0]  ptr_next;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .REQ     (REQ),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx  = PTR_W'(i);
        pick_data = DATA[XLAT_W*i +: XLAT_W];
      end
    end
  end

  assign ptr_next = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge CLK) begin
    if (MR) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      gnt_idx  <= '0;
      clr_pend <= 1'b0;
      GNT      <= '0;
      ACK      <= '0;
      BUSY     <= 1'b0;
      XD       <= '0;
      XCLK     <= 1'b0;
      XMR      <= 1'b1;
    end else begin
      ACK <= '0;
      // A clear request arriving mid-transaction waits for the next IDLE.
      if (CLR && state != IDLE) clr_pend <= 1'b1;
      case (state)
        IDLE: begin
          XMR <= 1'b0;
          if (CLR || clr_pend) begin
            state    <= CLRP;
            cnt      <= CNT_W'(CLRP_CYC - 1);
            XMR      <= 1'b1;
            BUSY     <= 1'b1;
            clr_pend <= 1'b0;
          end else if (any_req) begin
            state   <= SETUP;
            cnt     <= CNT_W'(SETUP_CYC - 1);
            GNT     <= pick;
            gnt_idx <= pick_idx;
            XD      <= pick_data;
            BUSY    <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= STROBE;
            cnt   <= CNT_W'(STROBE_CYC - 1);
            XCLK  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state <= SETTLE;
            cnt   <= CNT_W'(SETTLE_CYC - 1);
            XCLK  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= DONE;
            ACK   <= GNT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
          ptr   <= ptr_next;
        end
        CLRP: begin
          if (cnt == '0) begin
            state <= IDLE;
            XMR   <= 1'b0;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
          XCLK  <= 1'b0;
        end
      endcase
    end
  end

`ifdef XLAT_READBACK_EN
  logic clr_chk;

  // XQ must follow XD by DONE, and must read zero on the first IDLE after a clear pulse.
  always_ff @(posedge CLK) begin
    if (MR) begin
      RB_ERR  <= 1'b0;
      RB_CNT  <= '0;
      clr_chk <= 1'b0;
    end else begin
      clr_chk <= (state == CLRP) && (cnt == '0);
      if ((state == DONE && XQ != XD) || (state == IDLE && clr_chk && XQ != '0)) begin
        RB_ERR <= 1'b1;
        if (RB_CNT != 8'hFF) RB_CNT <= RB_CNT + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ecl_ttl_xlat_arbiter.sv
// tb/tb_ecl_ttl_xlat_arbiter.sv - self-checking bench for ecl_ttl_xlat_arbiter
module tb_ecl_ttl_xlat_arbiter;

  localparam int NREQ = 4;
  localparam int SCYC = 1;
  localparam int PCYC = 2;
  localparam int ECYC = 2;
  localparam int TOT  = SCYC + PCYC + ECYC + 1;
  localparam int CLRN = 2;

  logic              CLK;
  logic              MR;
  logic [NREQ-1:0]   REQ;
  logic [6*NREQ-1:0] DATA;
  logic              CLR;
  logic [NREQ-1:0]   ACK;
  logic [NREQ-1:0]   GNT;
  logic              BUSY;
  logic [5:0]        XD;
  logic              XCLK;
  logic              XMR;
`ifdef XLAT_READBACK_EN
  logic [5:0]        XQ;
  logic              RB_ERR;
  logic [7:0]        RB_CNT;
  logic [5:0]        xq_latch;
  logic              flip;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  ecl_ttl_xlat_arbiter #(
    .NREQ(NREQ), .SETUP_CYC(SCYC), .STROBE_CYC(PCYC), .SETTLE_CYC(ECYC), .CNT_W(4)
  ) dut (
    .CLK(CLK), .MR(MR), .REQ(REQ), .DATA(DATA), .CLR(CLR),
    .ACK(ACK), .GNT(GNT), .BUSY(BUSY), .XD(XD), .XCLK(XCLK), .XMR(XMR)
`ifdef XLAT_READBACK_EN
    , .XQ(XQ), .RB_ERR(RB_ERR), .RB_CNT(RB_CNT)
`endif
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

`ifdef XLAT_READBACK_EN
  always @(posedge CLK) begin
    if (XMR) xq_latch <= '0;
    else if (XCLK) xq_latch <= XD;
  end
  assign XQ = xq_latch ^ {5'b0, flip};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction model: kind 0 = idle, 1 = word transfer, 2 = clear pulse; age counts cycles in it.
  int        m_kind = 0, m_age = 0, m_g = 0, m_ptr = 0;
  bit        m_pend = 0, m_xmr_rst = 1;
  logic [5:0] m_xd = '0;

  always @(posedge CLK) begin
    if (MR) begin
      m_kind = 0; m_age = 0; m_ptr = 0; m_pend = 0; m_xmr_rst = 1; m_xd = '0;
    end else begin
      if (CLR && m_kind != 0) m_pend = 1;
      case (m_kind)
        0: begin
          m_xmr_rst = 0;
          if (CLR || m_pend) begin
            m_kind = 2; m_age = 1; m_pend = 0;
          end else if (REQ != 0) begin
            for (int i = NREQ - 1; i >= 0; i--)
              if (REQ[(m_ptr + i) % NREQ]) m_g = (m_ptr + i) % NREQ;
            m_kind = 1; m_age = 1; m_xd = DATA[6*m_g +: 6];
          end
        end
        1: if (m_age == TOT) begin m_kind = 0; m_ptr = (m_g + 1) % NREQ; end else m_age++;
        default: if (m_age == CLRN) m_kind = 0; else m_age++;
      endcase
    end
  end

  always @(negedge CLK) begin
    logic [NREQ-1:0] e_gnt, e_ack;
    if (cmp_en) begin
      e_gnt = (m_kind == 1) ? NREQ'(1 << m_g) : '0;
      e_ack = (m_kind == 1 && m_age == TOT) ? NREQ'(1 << m_g) : '0;
      chk("m_gnt", GNT, e_gnt);
      chk("m_ack", ACK, e_ack);
      chk("m_busy", BUSY, m_kind != 0);
      chk("m_xd", XD, m_xd);
      chk("m_xclk", XCLK, m_kind == 1 && m_age > SCYC && m_age <= SCYC + PCYC);
      chk("m_xmr", XMR, m_kind == 2 || m_xmr_rst);
    end
  end

  task automatic wait_for(input int sel, input int budget, input string name);
    bit hit = 0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge CLK);
      if (sel == 0 ? (ACK != 0) : (XCLK == 1'b1)) hit = 1;
    end
    chk(name, hit, 1);
  endtask

  initial begin
    int ack_cyc, ord[$], when[$];
    logic [7:0] xmask;
    MR = 1; REQ = 4'b1111; DATA = '0; CLR = 0;
`ifdef XLAT_READBACK_EN
    flip = 0;
`endif
    @(negedge CLK); cmp_en = 1;
    repeat (2) @(negedge CLK);
    chk("rst_gnt", GNT, 0); chk("rst_ack", ACK, 0); chk("rst_busy", BUSY, 0);
    chk("rst_xd", XD, 0); chk("rst_xclk", XCLK, 0); chk("rst_xmr", XMR, 1);
    MR = 0; REQ = 0;
    @(negedge CLK);
    chk("xmr_after_rst", XMR, 0);

    // single request to requester 2
    REQ = 4'b0100; DATA[12 +: 6] = 6'h2A;
    xmask = 0; ack_cyc = -1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      if (k == 1) begin chk("single_gnt", GNT, 4'b0100); chk("single_xd", XD, 6'h2A); end
      if (XCLK) xmask[k] = 1'b1;
      if (ACK == 4'b0100 && ack_cyc < 0) begin ack_cyc = k; REQ = 0; end
    end
    chk("single_xclk_cycles", xmask, 8'b0000_1100);
    chk("single_ack_cycle", ack_cyc, 6);

    // request withdrawn and data changed after grant
    REQ = 4'b0010; DATA[6 +: 6] = 6'h15;
    @(negedge CLK);
    chk("drop_gnt", GNT, 4'b0010);
    REQ = 0; DATA[6 +: 6] = 6'h3F;
    wait_for(0, 10, "drop_ack_seen");
    chk("drop_ack", ACK, 4'b0010); chk("drop_xd_frozen", XD, 6'h15);

    // round robin from a fresh pointer
    @(negedge CLK); MR = 1; REQ = 4'b1111;
    for (int i = 0; i < NREQ; i++) DATA[6*i +: 6] = 6'(6'h10 + i);
    @(negedge CLK); MR = 0;
    for (int c = 0; c < 60 && ord.size() < 5; c++) begin
      @(negedge CLK);
      for (int i = 0; i < NREQ; i++) if (ACK[i]) begin ord.push_back(i); when.push_back(c); end
    end
    REQ = 0;
    chk("rr_count", ord.size(), 5);
    if (ord.size() == 5) begin
      chk("rr_0", ord[0], 0); chk("rr_1", ord[1], 1); chk("rr_2", ord[2], 2);
      chk("rr_3", ord[3], 3); chk("rr_4", ord[4], 0);
      for (int i = 1; i < 5; i++) chk("rr_spacing", when[i] - when[i-1], 7);
    end
    repeat (2) @(negedge CLK);

    // CLR wins over REQ in the same cycle
    CLR = 1; REQ = 4'b0001;
    @(negedge CLK); CLR = 0;
    chk("clr_xmr1", XMR, 1); chk("clr_gnt1", GNT, 0);
    @(negedge CLK);
    chk("clr_xmr2", XMR, 1);
    @(negedge CLK);
    chk("clr_xmr3", XMR, 0); chk("clr_gnt3", GNT, 0);
    @(negedge CLK);
    chk("clr_then_gnt", GNT, 4'b0001);
    wait_for(0, 10, "clr_ack_seen"); REQ = 0;
    @(negedge CLK);

    // CLR during STROBE is deferred until after DONE, ahead of a waiting request
    REQ = 4'b1000;
    wait_for(1, 10, "pend_strobe_seen");
    CLR = 1;
    @(negedge CLK); CLR = 0;
    wait_for(0, 10, "pend_ack_seen");
    chk("pend_ack", ACK, 4'b1000);
    REQ = 4'b0001;
    @(negedge CLK);
    chk("pend_idle_xmr", XMR, 0); chk("pend_idle_busy", BUSY, 0);
    @(negedge CLK);
    chk("pend_clrp_xmr", XMR, 1); chk("pend_clrp_gnt", GNT, 0);
    wait_for(0, 15, "pend_req_ack_seen"); REQ = 0;
    @(negedge CLK);

    // abort during STROBE
    REQ = 4'b0100;
    wait_for(1, 10, "abort_strobe_seen");
    MR = 1;
    @(negedge CLK);
    chk("abort_xclk", XCLK, 0); chk("abort_gnt", GNT, 0); chk("abort_ack", ACK, 0);
    chk("abort_xmr", XMR, 1);
    MR = 0; REQ = 4'b1111;
    @(negedge CLK);
    chk("abort_ptr_reset", GNT, 4'b0001);
    wait_for(0, 10, "abort_next_ack_seen"); REQ = 0;
    @(negedge CLK);

`ifdef XLAT_READBACK_EN
    chk("rb_clean_err", RB_ERR, 0); chk("rb_clean_cnt", RB_CNT, 0);
    REQ = 4'b0010; flip = 1;
    wait_for(0, 10, "rb_ack_seen"); REQ = 0;
    @(negedge CLK); flip = 0;
    chk("rb_err", RB_ERR, 1); chk("rb_cnt", RB_CNT, 1);
    REQ = 4'b0001;
    wait_for(0, 10, "rb_ack2_seen"); REQ = 0;
    repeat (2) @(negedge CLK);
    chk("rb_err_held", RB_ERR, 1); chk("rb_cnt_held", RB_CNT, 1);
    MR = 1; @(negedge CLK); MR = 0; @(negedge CLK);
    chk("rb_err_mr", RB_ERR, 0); chk("rb_cnt_mr", RB_CNT, 0);
`endif

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
